shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Command sequencer sitting directly upstream of the 8-bit universal shift register (Shift_Register).
//   Accepts one command at a time over a valid/ready handshake: load, shift N steps, or rotate N steps.
//   Drives the register's s1/s0/sr/sl/d pins cycle by cycle and pulses done on completion.
//   Rotation uses the register's Q fed back on q_in.
// PARAMETERS
//   WIDTH  8  data width; must match the downstream register
//   CNT_W  4  step-count width; 0..2**CNT_W-1 steps per command
// PORTS
//   cp         in   1      clock; all state updates on rising edge
//   cr_        in   1      asynchronous active-low reset; shared with Shift_Register
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      controller can accept; transfer when cmd_valid & cmd_ready at a cp edge
//   cmd_op     in   3      000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROTR, 101 ROTL, 11x illegal (= NOP)
//   cmd_cnt    in   CNT_W  step count for SHR/SHL/ROTR/ROTL; ignored for LOAD/NOP
//   cmd_data   in   WIDTH  parallel value for LOAD
//   cmd_fill   in   1      serial fill bit for SHR/SHL
//   q_in       in   WIDTH  Shift_Register Q, used for rotate feedback
//   s1, s0     out  1 each mode: 00 hold, 01 SHR, 10 SHL, 11 load
//   sr, sl     out  1 each serial inputs to the register
//   d          out  WIDTH  parallel data to the register
//   busy       out  1      command in progress (EXEC or DONE)
//   done       out  1      one-cycle completion pulse
// BEHAVIOUR
//   Reset (cr_=0, immediate): state IDLE; s1=s0=0, sr=sl=0, d=0, busy=0, done=0, cmd_ready=1; regs cleared.
//   Register semantics: SHR Q<={Q[W-2:0],sr}; SHL Q<={sl,Q[W-1:1]}; load Q<=d.
//   FSM IDLE -> EXEC -> DONE -> IDLE; outputs are Moore, decoded from registered state/op/count/data.
//   IDLE: cmd_ready=1, mode 00. On handshake, latch op/cnt/data/fill into regs, go EXEC.
//   EXEC: cmd_ready=0, busy=1.
//     LOAD: mode 11, d=latched data for exactly one cycle, then DONE.
//     SHR/SHL: mode 01/10, sr/sl=latched fill; counter decrements each edge; leave EXEC after cnt edges.
//     ROTR: mode 01, sr=q_in[W-1]. ROTL: mode 10, sl=q_in[0]. Same count rules as shift.
//     NOP, illegal op, or shift/rotate with cnt==0: mode 00 for one cycle, no register change, then DONE.
//   DONE: mode 00, done=1 for one cycle, busy=1, cmd_ready=0; next edge -> IDLE.
//   Latency: accept at edge E0; register updates at E1..Ecnt (E1 for LOAD); done high in cycle after last update.
//   Throughput: one command per max(cnt,1)+2 cycles; back-to-back accept possible in cycle after DONE.
//   cmd_valid during EXEC/DONE is ignored and not latched; cmd_* may change freely after acceptance.
//   sr/sl: driven 0 when not used by the current mode; d = 0 outside LOAD.
//   Reset mid-command: aborts immediately; no done pulse; register is cleared by the same cr_.
//   cnt = 2**CNT_W-1 is legal; the counter never wraps below 0.
// STRUCTURE
//   Package shift_ctrl_pkg: op encodings (OP_NOP..OP_ROTL), mode encodings (MODE_HOLD/SHR/SHL/LOAD),
//     FSM state enum (ST_IDLE, ST_EXEC, ST_DONE).
//   Sub-module shift_step_counter: CNT_W down-counter with sync load, dec enable,
//     async clear on cr_, and a last flag (count==1).
//   Top: FSM, command latch, output decode.
// TESTING (bench = shift_seq_ctrl + Shift_Register sharing cp/cr_; 10 ns clock)
//   1. cr_=0 for 2 cycles -> all outputs 0, cmd_ready=1, Q=8'h00; release and idle 2 cycles -> Q stays 00.
//   2. LOAD cmd_data=8'hA5 -> s1s0=11 for 1 cycle, Q=8'hA5 one edge after accept,
//      done 1 cycle later, cmd_ready back the cycle after.
//   3. SHR fill=1 cnt=3 from A5 -> Q=8'h4B,8'h97,8'h2F on successive edges; done once;
//      then SHL fill=0 cnt=2 -> Q=8'h17,8'h0B.
//   4. LOAD 8'h81, ROTR cnt=3 -> Q=8'h03,8'h06,8'h0C; LOAD 8'h81, ROTL cnt=1 -> Q=8'hC0;
//      ROTR cnt=8 from 8'h0B -> Q=8'h0B.
//   5. SHR cnt=0, op=3'b111, op=NOP -> each gives s1s0=00, Q unchanged, done after 2 cycles;
//      cmd_valid held high during EXEC -> exactly one command accepted.
//   6. SHR fill=1 cnt=10 from 8'h00, drop cr_ after 4 shift edges -> all outputs 0 at once,
//      Q=00, no done pulse; next command accepted normally.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer.
package shift_ctrl_pkg;

  // Command opcodes as presented on cmd_op; 3'b110/3'b111 are illegal and act as NOP.
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROTR = 3'b100,
    OP_ROTL = 3'b101
  } op_e;

  // Downstream register mode pins {s1,s0}.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // Internal action latched at accept; folds illegal ops and zero-count steps into ACT_NONE.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_LOAD,
    ACT_SHR,
    ACT_SHL,
    ACT_ROTR,
    ACT_ROTL
  } act_e;

  function automatic act_e decode_act(input logic [2:0] op, input logic cnt_zero);
    act_e a;
    a = ACT_NONE;
    case (op)
      OP_LOAD: a = ACT_LOAD;
      OP_SHR:  a = cnt_zero ? ACT_NONE : ACT_SHR;
      OP_SHL:  a = cnt_zero ? ACT_NONE : ACT_SHL;
      OP_ROTR: a = cnt_zero ? ACT_NONE : ACT_ROTR;
      OP_ROTL: a = cnt_zero ? ACT_NONE : ACT_ROTL;
      default: a = ACT_NONE;
    endcase
    return a;
  endfunction

  function automatic mode_e act_mode(input act_e a);
    mode_e m;
    m = MODE_HOLD;
    case (a)
      ACT_LOAD:           m = MODE_LOAD;
      ACT_SHR, ACT_ROTR:  m = MODE_SHR;
      ACT_SHL, ACT_ROTL:  m = MODE_SHL;
      default:            m = MODE_HOLD;
    endcase
    return m;
  endfunction

  function automatic logic act_steps(input act_e a);
    return (a == ACT_SHR) || (a == ACT_SHL) || (a == ACT_ROTR) || (a == ACT_ROTL);
  endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Step down-counter: synchronous load, decrement enable, saturates at zero.
module shift_step_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             cp,
  input  logic             cr_,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Load has priority; decrement never goes below zero.
  always_ff @(posedge cp or negedge cr_) begin
    if (!cr_) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving an 8-bit universal shift register one step per cycle.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             cp,
  input  logic             cr_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] q_in,
  output logic             s1,
  output logic             s0,
  output logic             sr,
  output logic             sl,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done
);

  state_e           state;
  act_e             act;
  mode_e            mode_r;
  logic             fill_r;
  logic [WIDTH-1:0] d_r;
  logic             accept;
  act_e             next_act;
  logic [CNT_W-1:0] step_cnt;
  logic             step_last;
  logic             step_dec;
  logic             unused_q_mid;

  assign accept   = cmd_valid && cmd_ready && (state == ST_IDLE);
  assign next_act = decode_act(cmd_op, cmd_cnt == '0);
  assign step_dec = (state == ST_EXEC) && act_steps(act);

  shift_step_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .cp       (cp),
    .cr_      (cr_),
    .load     (accept),
    .load_val (cmd_cnt),
    .dec      (step_dec),
    .count    (step_cnt),
    .last     (step_last)
  );

  // Sequencer FSM; mode, data and handshake outputs are registered against the next state.
  always_ff @(posedge cp or negedge cr_) begin
    if (!cr_) begin
      state     <= ST_IDLE;
      act       <= ACT_NONE;
      mode_r    <= MODE_HOLD;
      fill_r    <= 1'b0;
      d_r       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_EXEC;
            act       <= next_act;
            mode_r    <= act_mode(next_act);
            fill_r    <= cmd_fill;
            d_r       <= (next_act == ACT_LOAD) ? cmd_data : '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end
        ST_EXEC: begin
          // Single-cycle actions leave at once; stepping ones leave on the last count.
          if (!act_steps(act) || step_last || (step_cnt == '0)) begin
            state  <= ST_DONE;
            mode_r <= MODE_HOLD;
            d_r    <= '0;
            done   <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          act       <= ACT_NONE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          act       <= ACT_NONE;
          mode_r    <= MODE_HOLD;
          d_r       <= '0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign {s1, s0} = mode_r;
  assign d        = d_r;

  // Serial inputs: fill bit for shifts, end bit of Q fed back for rotates, 0 otherwise.
  always_comb begin
    sr = 1'b0;
    sl = 1'b0;
    if (state == ST_EXEC) begin
      case (act)
        ACT_SHR:  sr = fill_r;
        ACT_SHL:  sl = fill_r;
        ACT_ROTR: sr = q_in[WIDTH-1];
        ACT_ROTL: sl = q_in[0];
        default: ;
      endcase
    end
  end

  // Only the end bits of Q matter for rotate feedback.
  assign unused_q_mid = ^q_in[WIDTH-2:1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench: sequencer plus a behavioural universal shift register, checked against a command-level model.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             cp = 1'b0;
  logic             cr_ = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_fill = 1'b0;
  logic [WIDTH-1:0] q;
  logic             s1, s0, sr, sl, busy, done;
  logic [WIDTH-1:0] d;

  always #5 cp = ~cp;

  shift_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .cp        (cp),
    .cr_       (cr_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .q_in      (q),
    .s1        (s1),
    .s0        (s0),
    .sr        (sr),
    .sl        (sl),
    .d         (d),
    .busy      (busy),
    .done      (done)
  );

  // Downstream Shift_Register behaviour.
  always_ff @(posedge cp or negedge cr_) begin
    if (!cr_) q <= '0;
    else begin
      case ({s1, s0})
        2'b01: q <= {q[WIDTH-2:0], sr};
        2'b10: q <= {sl, q[WIDTH-1:1]};
        2'b11: q <= d;
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic [1:0]       mode;
    logic             sr;
    logic             sl;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             done;
    logic             ready;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t             expq[$];
  logic [WIDTH-1:0] model_q = '0;
  logic             exp_ready_cur = 1'b1;
  int               n_vec = 0;
  int               n_bad = 0;
  int               done_seen = 0;

  // Requests from the stimulus process, consumed by the checker.
  int               lit_seq = 0;
  int               lit_seen = 0;
  string            lit_name = "";
  logic [WIDTH-1:0] lit_q = '0;
  int               lit_done = 0;
  int               tmo_seq = 0;
  int               tmo_seen = 0;

  // Expand one accepted command into the per-cycle outputs it must produce.
  task automatic model_accept(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                              input logic [WIDTH-1:0] data, input logic fill);
    exp_t e;
    logic [WIDTH-1:0] v;
    int steps;
    v = model_q;
    steps = (op >= 3'd2 && op <= 3'd5) ? int'(cnt) : 0;
    if (op == 3'd1) begin
      e = '{mode: 2'b11, sr: 1'b0, sl: 1'b0, d: data, busy: 1'b1, done: 1'b0, ready: 1'b0, q: v};
      expq.push_back(e);
      v = data;
    end else if (steps > 0) begin
      for (int k = 0; k < steps; k++) begin
        e = '{mode: 2'b00, sr: 1'b0, sl: 1'b0, d: '0, busy: 1'b1, done: 1'b0, ready: 1'b0, q: v};
        case (op)
          3'd2: begin e.mode = 2'b01; e.sr = fill;       v = {v[WIDTH-2:0], fill}; end
          3'd3: begin e.mode = 2'b10; e.sl = fill;       v = {fill, v[WIDTH-1:1]}; end
          3'd4: begin e.mode = 2'b01; e.sr = v[WIDTH-1]; v = {v[WIDTH-2:0], v[WIDTH-1]}; end
          default: begin e.mode = 2'b10; e.sl = v[0];    v = {v[0], v[WIDTH-1:1]}; end
        endcase
        expq.push_back(e);
      end
    end else begin
      e = '{mode: 2'b00, sr: 1'b0, sl: 1'b0, d: '0, busy: 1'b1, done: 1'b0, ready: 1'b0, q: v};
      expq.push_back(e);
    end
    e = '{mode: 2'b00, sr: 1'b0, sl: 1'b0, d: '0, busy: 1'b1, done: 1'b1, ready: 1'b0, q: v};
    expq.push_back(e);
    model_q = v;
  endtask

  // Model advances on the rising edge; outputs are compared on the falling edge.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge cp);
      if (cr_ && exp_ready_cur && cmd_valid)
        model_accept(cmd_op, cmd_cnt, cmd_data, cmd_fill);
      @(negedge cp);
      if (!cr_) begin
        expq.delete();
        model_q = '0;
        e = '{mode: 2'b00, sr: 1'b0, sl: 1'b0, d: '0, busy: 1'b0, done: 1'b0, ready: 1'b1, q: '0};
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
      end else begin
        e = '{mode: 2'b00, sr: 1'b0, sl: 1'b0, d: '0, busy: 1'b0, done: 1'b0, ready: 1'b1, q: model_q};
      end
      exp_ready_cur = e.ready;
      got = '{mode: {s1, s0}, sr: sr, sl: sl, d: d, busy: busy, done: done, ready: cmd_ready, q: q};
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t: got {mode,sr,sl,d,busy,done,ready,q}=%h required %h",
                 $time, got, e);
      end
      if (done === 1'b1) done_seen++;
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        n_vec++;
        if (q !== lit_q) begin
          n_bad++;
          $display("FAIL %s_q: got %h required %h", lit_name, q, lit_q);
        end
        n_vec++;
        if (done_seen != lit_done) begin
          n_bad++;
          $display("FAIL %s_done_count: got %0d required %0d", lit_name, done_seen, lit_done);
        end
      end
      if (tmo_seq != tmo_seen) begin
        tmo_seen = tmo_seq;
        n_vec++;
        n_bad++;
        $display("FAIL handshake_timeout: got no ready within bound, required ready at t=%0t", $time);
      end
    end
  end

  task automatic scramble();
    cmd_op   = 3'($urandom_range(0, 7));
    cmd_cnt  = CNT_W'($urandom_range(0, 15));
    cmd_data = WIDTH'($urandom);
    cmd_fill = 1'($urandom);
  endtask

  // All stimulus changes happen 2 time units after a rising edge.
  task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                      input logic [WIDTH-1:0] data, input logic fill, input int hold);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 60) begin
      @(posedge cp); #2;
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      tmo_seq++;
      @(posedge cp); #2;
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = data;
      cmd_fill  = fill;
      @(posedge cp); #2;
      repeat (hold) begin
        scramble();
        @(posedge cp); #2;
      end
      cmd_valid = 1'b0;
      scramble();
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(cmd_ready === 1'b1 && busy === 1'b0) && w < 60) begin
      @(posedge cp); #2;
      w++;
    end
    if (!(cmd_ready === 1'b1 && busy === 1'b0)) tmo_seq++;
  endtask

  task automatic lit(input string nm, input logic [WIDTH-1:0] qexp, input int dexp);
    lit_name = nm;
    lit_q    = qexp;
    lit_done = dexp;
    lit_seq++;
    @(posedge cp); #2;
  endtask

  initial begin
    int dexp;
    int hold;
    dexp = 0;
    cr_ = 1'b0;
    repeat (2) @(posedge cp);
    #2;
    lit("reset", 8'h00, 0);
    cr_ = 1'b1;
    repeat (2) @(posedge cp);
    #2;
    lit("idle_after_reset", 8'h00, 0);

    send(3'b001, 4'd0, 8'hA5, 1'b0, 0); wait_idle(); dexp++; lit("load_a5", 8'hA5, dexp);
    send(3'b010, 4'd3, 8'h00, 1'b1, 0); wait_idle(); dexp++; lit("shr3", 8'h2F, dexp);
    send(3'b011, 4'd2, 8'h00, 1'b0, 0); wait_idle(); dexp++; lit("shl2", 8'h0B, dexp);

    send(3'b001, 4'd0, 8'h81, 1'b0, 0); wait_idle(); dexp++;
    send(3'b100, 4'd3, 8'h00, 1'b0, 0); wait_idle(); dexp++; lit("rotr3", 8'h0C, dexp);
    send(3'b001, 4'd0, 8'h81, 1'b0, 0); wait_idle(); dexp++;
    send(3'b101, 4'd1, 8'h00, 1'b0, 0); wait_idle(); dexp++; lit("rotl1", 8'hC0, dexp);
    send(3'b001, 4'd0, 8'h0B, 1'b0, 0); wait_idle(); dexp++;
    send(3'b100, 4'd8, 8'h00, 1'b0, 0); wait_idle(); dexp++; lit("rotr8", 8'h0B, dexp);

    send(3'b010, 4'd0, 8'hFF, 1'b1, 2); wait_idle(); dexp++; lit("shr_cnt0", 8'h0B, dexp);
    send(3'b111, 4'd5, 8'hFF, 1'b1, 2); wait_idle(); dexp++; lit("illegal_op", 8'h0B, dexp);
    send(3'b000, 4'd5, 8'hFF, 1'b1, 2); wait_idle(); dexp++; lit("nop", 8'h0B, dexp);
    send(3'b011, 4'd15, 8'h00, 1'b1, 0); wait_idle(); dexp++; lit("shl15", 8'hFF, dexp);

    send(3'b001, 4'd0, 8'h00, 1'b0, 0); wait_idle(); dexp++;
    send(3'b010, 4'd10, 8'h00, 1'b1, 0);
    repeat (4) @(posedge cp);
    #2;
    cr_ = 1'b0;
    lit("abort", 8'h00, dexp);
    cr_ = 1'b1;
    @(posedge cp); #2;
    send(3'b001, 4'd0, 8'h3C, 1'b0, 0); wait_idle(); dexp++; lit("after_abort", 8'h3C, dexp);

    for (int i = 0; i < 150; i++) begin
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(3'($urandom_range(0, 7)), CNT_W'($urandom_range(0, 15)), WIDTH'($urandom),
           1'($urandom), hold);
    end
    wait_idle();
    repeat (3) @(posedge cp);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion before t=2000000");
    $fatal(1);
  end

endmodule
